hex_rotation_monitor: RTL and testbench

//  Receive-side checker for the rotating four-digit "dE10" message driven onto HEX3..HEX0.
//  - Samples the four 7-seg buses on a strobe and decodes each active-low pattern to a glyph.
//  - Recovers the rotation offset and locks onto the advancing sequence.
//  - Flags errors and keeps good/bad frame counts for on-board self-test or simulation.

---
 rtl/hex_disp_pkg.sv | 22 ++
 rtl/seg7_glyph_decode.sv | 23 ++
 rtl/hex_rotation_monitor.sv | 165 ++++++++++++++++
 tb/tb_hex_rotation_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the "dE10" seven-segment display path: glyph patterns,
// glyph codes and the monitor state encoding.
package hex_disp_pkg;

   // Active-low segment patterns {g,f,e,d,c,b,a}
   localparam logic [6:0] GLYPH_D = 7'b0100001;
   localparam logic [6:0] GLYPH_E = 7'b0000110;
   localparam logic [6:0] GLYPH_1 = 7'b1111001;
   localparam logic [6:0] GLYPH_0 = 7'b1000000;

   localparam logic [1:0] CODE_D = 2'd0;
   localparam logic [1:0] CODE_E = 2'd1;
   localparam logic [1:0] CODE_1 = 2'd2;
   localparam logic [1:0] CODE_0 = 2'd3;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_LOCKED = 2'd1,
      ST_ERROR  = 2'd2
   } mon_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of one active-low seven-segment pattern into a glyph code.
module seg7_glyph_decode
   import hex_disp_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       valid,
   output logic [1:0] code
);

   // Pattern lookup; anything outside the four glyphs is invalid
   always_comb begin
      valid = 1'b0;
      code  = 2'd0;
      case (pattern)
         GLYPH_D: begin valid = 1'b1; code = CODE_D; end
         GLYPH_E: begin valid = 1'b1; code = CODE_E; end
         GLYPH_1: begin valid = 1'b1; code = CODE_1; end
         GLYPH_0: begin valid = 1'b1; code = CODE_0; end
         default: begin valid = 1'b0; code = 2'd0; end
      endcase
   end

endmodule

// File: rtl/hex_rotation_monitor.sv
// Receive-side checker for the rotating "dE10" message on HEX3..HEX0: solves the
// rotation offset, locks onto the advancing sequence and keeps good/bad statistics.
module hex_rotation_monitor
   import hex_disp_pkg::*;
#(
   parameter int LOCK_FRAMES = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_en,
   input  logic [6:0]       hex0,
   input  logic [6:0]       hex1,
   input  logic [6:0]       hex2,
   input  logic [6:0]       hex3,
   input  logic             clear_err,
   output logic             frame_ok,
   output logic [1:0]       offset,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   localparam logic [3:0] LOCK_RUN = 4'(LOCK_FRAMES);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   logic [6:0]       hex_s [4];
   logic [3:0]       valid_s;
   logic [1:0]       code_s [4];
   logic [1:0]       k_s, exp1_s, exp2_s, exp3_s;
   logic             legal_s, succ_s, in_seq_s;

   mon_state_e       state_r, state_nxt_s;
   logic [3:0]       run_r, run_nxt_s;
   logic             frame_ok_r, frame_ok_nxt_s;
   logic [1:0]       offset_r, offset_nxt_s;
   logic             locked_r, err_r, err_nxt_s;
   logic [CNT_W-1:0] good_r, good_nxt_s, bad_r, bad_nxt_s;

   assign hex_s[0] = hex0;
   assign hex_s[1] = hex1;
   assign hex_s[2] = hex2;
   assign hex_s[3] = hex3;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      seg7_glyph_decode u_dec (
         .pattern (hex_s[gi]),
         .valid   (valid_s[gi]),
         .code    (code_s[gi])
      );
   end

   // Offset solver: hex0 fixes k, the other three digits must agree (mod-4 arithmetic)
   always_comb begin
      k_s      = CODE_0 - code_s[0];
      exp1_s   = CODE_1 - k_s;
      exp2_s   = CODE_E - k_s;
      exp3_s   = CODE_D - k_s;
      legal_s  = (&valid_s) && (code_s[1] == exp1_s) && (code_s[2] == exp2_s)
                 && (code_s[3] == exp3_s);
      succ_s   = (k_s == (offset_r + 2'd1));
      in_seq_s = legal_s && succ_s;
   end

   // Next-state, run and statistics logic; clear_err takes priority over a strobe
   always_comb begin
      state_nxt_s    = state_r;
      run_nxt_s      = run_r;
      frame_ok_nxt_s = frame_ok_r;
      offset_nxt_s   = offset_r;
      err_nxt_s      = err_r;
      good_nxt_s     = good_r;
      bad_nxt_s      = bad_r;
      if (clear_err) begin
         state_nxt_s = ST_SEARCH;
         run_nxt_s   = 4'd0;
         err_nxt_s   = 1'b0;
      end else if (sample_en) begin
         frame_ok_nxt_s = legal_s;
         if (legal_s) begin
            offset_nxt_s = k_s;
         end else begin
            offset_nxt_s = offset_r;
         end
         case (state_r)
            ST_SEARCH: begin
               if (!legal_s) begin
                  run_nxt_s = 4'd0;
                  bad_nxt_s = sat_inc(bad_r);
               end else if ((run_r == 4'd0) || !succ_s) begin
                  run_nxt_s = 4'd1;
               end else begin
                  run_nxt_s = run_r + 4'd1;
               end
               if (run_nxt_s == LOCK_RUN) begin
                  state_nxt_s = ST_LOCKED;
               end else begin
                  state_nxt_s = ST_SEARCH;
               end
            end
            ST_LOCKED: begin
               if (in_seq_s) begin
                  good_nxt_s = sat_inc(good_r);
               end else begin
                  bad_nxt_s   = sat_inc(bad_r);
                  err_nxt_s   = 1'b1;
                  state_nxt_s = ST_ERROR;
               end
            end
            ST_ERROR: begin
               if (in_seq_s) begin
                  bad_nxt_s = bad_r;
               end else begin
                  bad_nxt_s = sat_inc(bad_r);
               end
            end
            default: begin
               state_nxt_s = ST_SEARCH;
               run_nxt_s   = 4'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_SEARCH;
         run_r      <= 4'd0;
         frame_ok_r <= 1'b0;
         offset_r   <= 2'd0;
         locked_r   <= 1'b0;
         err_r      <= 1'b0;
         good_r     <= '0;
         bad_r      <= '0;
      end else begin
         state_r    <= state_nxt_s;
         run_r      <= run_nxt_s;
         frame_ok_r <= frame_ok_nxt_s;
         offset_r   <= offset_nxt_s;
         locked_r   <= (state_nxt_s == ST_LOCKED);
         err_r      <= err_nxt_s;
         good_r     <= good_nxt_s;
         bad_r      <= bad_nxt_s;
      end
   end

   assign frame_ok = frame_ok_r;
   assign offset   = offset_r;
   assign locked   = locked_r;
   assign err      = err_r;
   assign good_cnt = good_r;
   assign bad_cnt  = bad_r;

endmodule

// File: tb/tb_hex_rotation_monitor.sv
// Scoreboard bench for hex_rotation_monitor: directed scenarios plus random frames,
// checked against a message-level reference model on a 16-bit and a 4-bit instance.
module tb_hex_rotation_monitor;

   logic clk = 1'b0;
   logic rst_n = 1'b0, sample_en = 1'b0, clear_err = 1'b0;
   logic [6:0] hex0 = 7'h7F, hex1 = 7'h7F, hex2 = 7'h7F, hex3 = 7'h7F;

   logic        a_ok, b_ok, a_lk, b_lk, a_err, b_err;
   logic [1:0]  a_off, b_off;
   logic [15:0] a_good, a_bad;
   logic [3:0]  b_good, b_bad;

   always #5 clk = ~clk;

   hex_rotation_monitor #(.LOCK_FRAMES(4), .CNT_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .clear_err(clear_err),
      .frame_ok(a_ok), .offset(a_off), .locked(a_lk), .err(a_err),
      .good_cnt(a_good), .bad_cnt(a_bad));

   hex_rotation_monitor #(.LOCK_FRAMES(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .clear_err(clear_err),
      .frame_ok(b_ok), .offset(b_off), .locked(b_lk), .err(b_err),
      .good_cnt(b_good), .bad_cnt(b_bad));

   typedef struct {
      int ok; int off; int lk; int er; int good; int bad;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, errors = 0;

   // Reference model: message-level view of the monitor
   int   m_ok, m_off, m_err, m_good, m_bad, m_run;
   bit   m_locked, m_errstate;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // The frame shown for rotation k: digit i carries symbol (3-i-k) mod 4 of "dE10"
   function automatic logic [27:0] frame_k(input int k);
      logic [6:0] g [4];
      logic [27:0] f;
      g[0] = 7'b0100001; g[1] = 7'b0000110; g[2] = 7'b1111001; g[3] = 7'b1000000;
      for (int i = 0; i < 4; i++) f[7*i +: 7] = g[(3 - i - k) & 3];
      return f;
   endfunction

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_step(input logic rst, input logic se, input logic ce,
                             input logic [27:0] fr);
      int k;
      bit legal, seq;
      if (!rst) begin
         m_ok = 0; m_off = 0; m_err = 0; m_good = 0; m_bad = 0; m_run = 0;
         m_locked = 0; m_errstate = 0;
      end else if (ce) begin
         m_err = 0; m_run = 0; m_locked = 0; m_errstate = 0;
      end else if (se) begin
         legal = 0; k = 0;
         for (int c = 0; c < 4; c++) if (fr == frame_k(c)) begin legal = 1; k = c; end
         seq = legal && (k == ((m_off + 1) % 4));
         m_ok = legal;
         if (m_locked) begin
            if (seq) m_good++;
            else begin m_bad++; m_err = 1; m_locked = 0; m_errstate = 1; end
         end else if (m_errstate) begin
            if (!seq) m_bad++;
         end else begin
            if (!legal) begin m_run = 0; m_bad++; end
            else if (m_run == 0 || !seq) m_run = 1;
            else m_run++;
            if (m_run == 4) m_locked = 1;
         end
         if (legal) m_off = k;
      end
   endtask

   // One clock of stimulus; expected response is queued for the monitor
   task automatic cyc(input logic rst, input logic se, input logic ce, input logic [27:0] fr);
      exp_t e;
      @(negedge clk);
      rst_n = rst; sample_en = se; clear_err = ce;
      {hex3, hex2, hex1, hex0} = fr;
      model_step(rst, se, ce, fr);
      e.ok = m_ok; e.off = m_off; e.lk = m_locked; e.er = m_err;
      e.good = m_good; e.bad = m_bad;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic legal(input int k);
      cyc(1'b1, 1'b1, 1'b0, frame_k(k & 3));
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, 28'h0);
   endtask

   // Monitor: compare both instances after every driven edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("frame_ok", int'(a_ok), e.ok);
         chk("offset", int'(a_off), e.off);
         chk("locked", int'(a_lk), e.lk);
         chk("err", int'(a_err), e.er);
         chk("good_cnt", int'(a_good), sat(e.good, 16));
         chk("bad_cnt", int'(a_bad), sat(e.bad, 16));
         chk("w4_locked", int'(b_lk), e.lk);
         chk("w4_good_cnt", int'(b_good), sat(e.good, 4));
         chk("w4_bad_cnt", int'(b_bad), sat(e.bad, 4));
      end
   end

   initial begin
      logic [27:0] fr;
      int r, k;
      // Reset state
      cyc(1'b0, 1'b0, 1'b0, 28'h0);
      cyc(1'b0, 1'b0, 1'b0, 28'h0);
      chk("reset_locked", int'(a_lk), 0);
      chk("reset_good", int'(a_good), 0);
      // Lock after the fourth in-sequence frame
      for (int i = 0; i < 8; i++) begin
         legal(i);
         if (i == 2) chk("t1_not_locked_3", int'(a_lk), 0);
         if (i == 3) chk("t1_locked_4", int'(a_lk), 1);
      end
      chk("t1_good", int'(a_good), 4);
      chk("t1_bad", int'(a_bad), 0);
      chk("t1_err", int'(a_err), 0);
      // Corrupt hex1 while locked
      fr = frame_k(0);
      fr[13:7] = 7'h7F;
      cyc(1'b1, 1'b1, 1'b0, fr);
      chk("t2_frame_ok", int'(a_ok), 0);
      chk("t2_err", int'(a_err), 1);
      chk("t2_locked", int'(a_lk), 0);
      chk("t2_bad", int'(a_bad), 1);
      cyc(1'b1, 1'b0, 1'b1, 28'h0);
      for (int i = 1; i <= 4; i++) legal(i);
      chk("t2_relock", int'(a_lk), 1);
      // clear_err with a simultaneous strobe in ERROR
      cyc(1'b1, 1'b1, 1'b0, 28'h0);
      chk("t4_err_set", int'(a_err), 1);
      cyc(1'b1, 1'b1, 1'b1, frame_k(1));
      chk("t4_err", int'(a_err), 0);
      chk("t4_offset", int'(a_off), 0);
      chk("t4_frame_ok", int'(a_ok), 0);
      chk("t4_bad", int'(a_bad), 2);
      chk("t4_good", int'(a_good), 4);
      // Repeated offset breaks the run
      legal(0); legal(1); legal(1); legal(2); legal(3);
      chk("t3_not_locked_5", int'(a_lk), 0);
      legal(0);
      chk("t3_locked_6", int'(a_lk), 1);
      chk("t3_bad", int'(a_bad), 2);
      // Legal glyphs, illegal order, in SEARCH
      cyc(1'b1, 1'b0, 1'b1, 28'h0);
      legal(0); legal(1);
      cyc(1'b1, 1'b1, 1'b0, {7'b0100001, 7'b1111001, 7'b0000110, 7'b1000000});
      chk("t6_frame_ok", int'(a_ok), 0);
      chk("t6_bad", int'(a_bad), 3);
      legal(2); legal(3); legal(0);
      chk("t6_run_reset", int'(a_lk), 0);
      legal(1);
      chk("t6_lock", int'(a_lk), 1);
      // Saturation of the 4-bit instance, then reset
      cyc(1'b0, 1'b0, 1'b0, 28'h0);
      for (int i = 0; i < 24; i++) legal(i);
      chk("t5_good_w4", int'(b_good), 15);
      chk("t5_good_w16", int'(a_good), 20);
      idle();
      chk("t5_hold_w4", int'(b_good), 15);
      cyc(1'b0, 1'b1, 1'b0, frame_k(m_off + 1));
      chk("t5_rst_good", int'(b_good), 0);
      chk("t5_rst_locked", int'(b_lk), 0);
      chk("t5_rst_offset", int'(b_off), 0);
      // Random traffic
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         k = int'($urandom_range(0, 3));
         if (r < 2) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, frame_k(k));
         else if (r < 6) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, frame_k(k));
         else if (r < 20) idle();
         else if (r < 75) legal(m_off + 1);
         else if (r < 83) legal(k);
         else if (r < 92) begin
            fr = frame_k(m_off + 1);
            fr[7*k +: 7] = 7'($urandom_range(0, 127));
            cyc(1'b1, 1'b1, 1'b0, fr);
         end else begin
            for (int i = 0; i < 4; i++) fr[7*i +: 7] = frame_k(0) >> (7 * $urandom_range(0, 3));
            cyc(1'b1, 1'b1, 1'b0, fr);
         end
      end
      idle();
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
